// File: rtl/gen_tone_pkg.sv
// Shared types and default sizing for the gen_tone DDS tone generator.
package gen_tone_pkg;

    localparam int PHASE_W_DEF = 24;
    localparam int OUT_W_DEF   = 16;
    localparam int AMP_W_DEF   = 9;

    typedef enum logic [1:0] {
        MODE_SILENCE = 2'd0,
        MODE_SQUARE  = 2'd1,
        MODE_SAW     = 2'd2,
        MODE_TRI     = 2'd3
    } mode_e;

endpackage

// File: rtl/gen_tone_phase.sv
// Phase accumulator: advances by freq_word on each enabled tick, held at 0 while disabled.
// wrapped_o flags that the current phase value was produced by an accumulator overflow.
module gen_tone_phase
    import gen_tone_pkg::*;
#(
    parameter int PHASE_W = PHASE_W_DEF
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               enable_i,
    input  logic               tick_i,
    input  logic [PHASE_W-1:0] freq_word_i,
    output logic [PHASE_W-1:0] phase_o,
    output logic               wrapped_o
);

    logic [PHASE_W-1:0] phase_q, phase_d;
    logic               carry_q, carry_d;

    always_comb begin
        phase_d = phase_q;
        carry_d = carry_q;
        if (!enable_i) begin
            phase_d = '0;
            carry_d = 1'b0;
        end else if (tick_i) begin
            {carry_d, phase_d} = {1'b0, phase_q} + {1'b0, freq_word_i};
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            phase_q <= '0;
            carry_q <= 1'b0;
        end else begin
            phase_q <= phase_d;
            carry_q <= carry_d;
        end
    end

    assign phase_o   = phase_q;
    assign wrapped_o = carry_q;

endmodule

// File: rtl/gen_tone.sv
// DDS tone generator: square/saw (triangle with GEN_TONE_TRIANGLE_EN), amplitude-scaled and saturated.
// Two-stage pipeline: tick at cycle N yields out_valid/wrap at N+2; one sample per tick, no stalls.
module gen_tone
    import gen_tone_pkg::*;
#(
    parameter int PHASE_W = PHASE_W_DEF,
    parameter int OUT_W   = OUT_W_DEF,
    parameter int AMP_W   = AMP_W_DEF
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    enable,
    input  logic                    tick,
    input  logic [PHASE_W-1:0]      freq_word,
    input  logic [1:0]              mode,
    input  logic [AMP_W-1:0]        amp,
    output logic signed [OUT_W-1:0] out,
    output logic                    out_valid,
    output logic                    wrap
);

    localparam int PROD_W = OUT_W + AMP_W + 1;

    localparam logic [OUT_W-1:0] M_BITS   = {1'b1, {(OUT_W-1){1'b0}}};
    localparam logic [OUT_W-1:0] FULL_POS = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic [OUT_W-1:0] FULL_NEG = {1'b1, {(OUT_W-2){1'b0}}, 1'b1};

    localparam logic signed [PROD_W-1:0] SAT_MAX = {{(AMP_W+2){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [PROD_W-1:0] SAT_MIN = {{(AMP_W+2){1'b1}}, {(OUT_W-1){1'b0}}};

    logic [PHASE_W-1:0] phase;
    logic               phase_wrapped;

    gen_tone_phase #(
        .PHASE_W (PHASE_W)
    ) u_phase (
        .clock       (clock),
        .reset_n     (reset_n),
        .enable_i    (enable),
        .tick_i      (tick),
        .freq_word_i (freq_word),
        .phase_o     (phase),
        .wrapped_o   (phase_wrapped)
    );

    // Low phase bits only matter for finer shapes than OUT_W resolves.
    logic unused_phase_lsbs;
    assign unused_phase_lsbs = ^phase[PHASE_W-OUT_W-1:0];

    // Stage 1: waveform shape from the current phase.
    logic [OUT_W-1:0] shape_d;
`ifdef GEN_TONE_TRIANGLE_EN
    logic [OUT_W-1:0] tri_u;
`endif

    always_comb begin
        shape_d = '0;
`ifdef GEN_TONE_TRIANGLE_EN
        tri_u = phase[PHASE_W-2 -: OUT_W];
        if (phase[PHASE_W-1]) begin
            tri_u = ~tri_u;
        end
`endif
        case (mode_e'(mode))
            MODE_SQUARE: shape_d = phase[PHASE_W-1] ? FULL_NEG : FULL_POS;
            MODE_SAW:    shape_d = phase[PHASE_W-1 -: OUT_W] - M_BITS;
`ifdef GEN_TONE_TRIANGLE_EN
            MODE_TRI:    shape_d = tri_u - M_BITS;
`endif
            default:     shape_d = '0;
        endcase
    end

    logic signed [OUT_W-1:0] s1_shape_q;
    logic [AMP_W-1:0]        s1_amp_q;
    logic                    s1_vld_q;
    logic                    s1_wrap_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            s1_shape_q <= '0;
            s1_amp_q   <= '0;
            s1_vld_q   <= 1'b0;
            s1_wrap_q  <= 1'b0;
        end else if (!enable) begin
            s1_shape_q <= '0;
            s1_amp_q   <= '0;
            s1_vld_q   <= 1'b0;
            s1_wrap_q  <= 1'b0;
        end else if (tick) begin
            s1_shape_q <= shape_d;
            s1_amp_q   <= amp;
            s1_vld_q   <= 1'b1;
            s1_wrap_q  <= phase_wrapped;
        end else begin
            s1_vld_q   <= 1'b0;
            s1_wrap_q  <= 1'b0;
        end
    end

    // Stage 2: signed x unsigned scale, unity gain at 2^(AMP_W-1), then clamp.
    logic signed [PROD_W-1:0] prod;
    logic signed [PROD_W-1:0] scaled;
    logic [OUT_W-1:0]         sat_d;

    always_comb begin
        prod   = PROD_W'(s1_shape_q) * PROD_W'($signed({1'b0, s1_amp_q}));
        scaled = prod >>> (AMP_W - 1);
        if (scaled > SAT_MAX) begin
            sat_d = SAT_MAX[OUT_W-1:0];
        end else if (scaled < SAT_MIN) begin
            sat_d = SAT_MIN[OUT_W-1:0];
        end else begin
            sat_d = scaled[OUT_W-1:0];
        end
    end

    logic [OUT_W-1:0] out_q;
    logic             out_valid_q;
    logic             wrap_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            out_q       <= '0;
            out_valid_q <= 1'b0;
            wrap_q      <= 1'b0;
        end else if (!enable) begin
            out_q       <= '0;
            out_valid_q <= 1'b0;
            wrap_q      <= 1'b0;
        end else if (s1_vld_q) begin
            out_q       <= sat_d;
            out_valid_q <= 1'b1;
            wrap_q      <= s1_wrap_q;
        end else begin
            out_valid_q <= 1'b0;
            wrap_q      <= 1'b0;
        end
    end

    assign out       = out_q;
    assign out_valid = out_valid_q;
    assign wrap      = wrap_q;

endmodule

// File: doc/gen_tone.md
# gen_tone

Parametrised DDS tone generator; successor to the fixed-amplitude square generator. A phase accumulator, stepped once per audio sample tick, produces square, sawtooth or (optionally) triangle waveforms. Output is signed two's-complement with programmable amplitude and saturation. The block sits between the sample-rate tick source and the audio mixer/DAC serialiser, and delivers one `out_valid`-qualified sample per tick.

## Interface
- `PHASE_W`, 24: phase accumulator width; must be ≥ `OUT_W`+1
- `OUT_W`, 16: output sample width (signed)
- `AMP_W`, 9: amplitude width (unsigned); unity gain = 2^(`AMP_W`-1)

- `clock` in 1: system clock
- `reset_n` in 1: asynchronous, active-low reset
- `enable` in 1: generator run; low forces phase and output to 0
- `tick` in 1: one-cycle sample strobe (e.g. 48 kHz enable)
- `freq_word` in `PHASE_W`: phase increment per tick; f_out = f_tick·freq_word/2^`PHASE_W`
- `mode` in 2: 0 silence, 1 square, 2 saw, 3 triangle
- `amp` in `AMP_W`: amplitude
- `out` out `OUT_W`: signed sample
- `out_valid` out 1: one-cycle pulse when `out` is updated
- `wrap` out 1: one-cycle pulse, coincident with `out_valid`, when the phase accumulator overflowed for that sample

## Operation
- Reset (async, `reset_n`=0): phase=0, `out`=0, `out_valid`=0, `wrap`=0, pipeline cleared.
- Stage 1, on a cycle with `tick`=1 and `enable`=1: shape computed from the *current* phase p; phase ← (p + `freq_word`) mod 2^`PHASE_W`; `freq_word`, `mode` and `amp` are sampled in this cycle only; carry-out recorded for `wrap`.
- Shapes (signed `OUT_W`, M = 2^(`OUT_W`-1)):
  - square: p MSB=0 → +(M-1), else −(M-1)
  - saw: p[`PHASE_W`-1 -: `OUT_W`] − M
  - triangle: u = p[`PHASE_W`-2 -: `OUT_W`]; if p MSB=1 then u = ~u; shape = u − M
  - silence: 0
- Stage 2: product = shape × `amp` (signed × unsigned, `OUT_W`+`AMP_W`+1 bits), arithmetic shift right by `AMP_W`-1, then saturate to [−M, M−1]; registered to `out`; `out_valid`=1 for one cycle.
- `enable`=0: phase held at 0; ticks ignored; `out` cleared to 0 on the next clock; no `out_valid`. Re-enable: the first sample uses phase 0.
- `tick` while `enable`=0 is dropped, not queued.
- `freq_word`=0: constant phase, valid samples still produced, `wrap` never asserted.
- `mode`=3 with triangle compiled out: treated as silence.

## Timing
- Latency: `tick` at cycle N → `out_valid`/`wrap` at N+2.
- Back-to-back ticks: one sample per cycle, fully pipelined, none lost.
- `out` holds its value between `out_valid` pulses.
- `enable` falling while a sample is in stage 2: that sample is discarded (no `out_valid`); `out`=0 on the next clock.

## Configuration
- `GEN_TONE_TRIANGLE_EN` defined: mode 3 produces triangle.
- Undefined: triangle fold logic is absent; mode 3 outputs 0 with `out_valid` still pulsing.

## Structure
- Package `gen_tone_pkg`: mode enum (`MODE_SILENCE`, `MODE_SQUARE`, `MODE_SAW`, `MODE_TRI`) and the default parameter constants.
- Sub-module `gen_tone_phase`: phase accumulator with tick/enable gating and the carry-out (`wrap`) register; shaping and scaling stay in the top level.

## Test plan
- Defaults, `mode`=1, `freq_word`=0x400000, `amp`=256, `enable`=1, 4 ticks → `out` = 32767, 32767, −32767, −32767; `wrap` is asserted with the 1st sample after the overflow, i.e. sample 5 on a 5th tick.
- `mode`=2, same `freq_word`, `amp`=256 → −32768, −16384, 0, 16384.
- `mode`=3 (`GEN_TONE_TRIANGLE_EN`), same → −32768, 0, 32767, −1; without the macro → 0, 0, 0, 0 with 4 `out_valid` pulses.
- `mode`=1, `amp`=511 → +32767 and −32768 (saturated); `amp`=128 → 16383, −16384.
- Ticks on 3 consecutive cycles → 3 `out_valid` pulses at N+2, N+3, N+4; `tick` at N then `enable`=0 at N+1 → no `out_valid`, `out`=0.
- `reset_n` asserted mid-stream (asynchronously, between clock edges) → `out`, `out_valid`, `wrap` = 0 immediately; after release, the first sample equals the phase-0 value.
